// File: rtl/pc_seq.sv
// pc_seq: program-sequencing unit producing the registered instruction fetch
// address. Supports increment, absolute/relative branch and, when the macro
// PC_SEQ_CALLSTACK_EN is defined, call/return through a circular return stack.
// Without the macro no stack is built: call is an absolute jump, ret is
// ignored, stk_full=0, stk_empty=1 and stk_err=0.
module pc_seq #(
  parameter int unsigned       ADDR_W     = 8,
  parameter int unsigned       DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              brnch_yes,
  input  logic              brnch_rel,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] regBuf,
  output logic [ADDR_W-1:0] addr,
  output logic              stk_full,
  output logic              stk_empty,
  output logic              stk_err
);

  if (ADDR_W < 4) begin : g_bad_addr_w
    $error("pc_seq: ADDR_W must be at least 4");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("pc_seq: DEPTH must be at least 1");
  end

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_inc;
  logic [ADDR_W-1:0] w_addr_nxt;

  // Relative offsets are ADDR_W wide, so a plain modulo add is the sign-extended add.
  assign w_addr_inc = r_addr + ADDR_W'(1);
  assign addr       = r_addr;

`ifdef PC_SEQ_CALLSTACK_EN

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] r_stk [DEPTH];
  logic [PTR_W-1:0]  r_wp;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;

  logic [PTR_W-1:0]  w_wp_inc;
  logic [PTR_W-1:0]  w_wp_dec;
  logic [ADDR_W-1:0] w_top;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_err_set;

  // r_wp is the next free slot; on overflow it keeps circling so the oldest entry is overwritten.
  always_comb begin
    w_wp_inc = (r_wp == PTR_W'(DEPTH - 1)) ? '0 : r_wp + PTR_W'(1);
    w_wp_dec = (r_wp == '0) ? PTR_W'(DEPTH - 1) : r_wp - PTR_W'(1);
    w_top    = r_stk[w_wp_dec];
    w_full   = (r_cnt == CNT_W'(DEPTH));
    w_empty  = (r_cnt == '0);
  end

  // Prioritised action select: ret > call > relative branch > absolute branch > increment.
  always_comb begin
    w_addr_nxt = w_addr_inc;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_err_set  = 1'b0;
    if (ret) begin
      if (call) begin
        w_err_set = 1'b1;
      end
      if (!w_empty) begin
        w_addr_nxt = w_top;
        w_pop      = 1'b1;
      end else begin
        w_err_set  = 1'b1;
      end
    end else if (call) begin
      w_push     = 1'b1;
      w_addr_nxt = regBuf;
      if (w_full) begin
        w_err_set = 1'b1;
      end
    end else if (brnch_yes) begin
      if (brnch_rel) begin
        w_addr_nxt = r_addr + regBuf;
      end else begin
        w_addr_nxt = regBuf;
      end
    end
  end

  // Address, stack pointer, occupancy count and sticky error; all hold while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= RESET_ADDR;
      r_wp   <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else if (en) begin
      r_addr <= w_addr_nxt;
      if (w_push) begin
        r_wp <= w_wp_inc;
        if (!w_full) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else if (w_pop) begin
        r_wp  <= w_wp_dec;
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  // Stack storage carries no reset; entries are only ever read below the count.
  always_ff @(posedge clk) begin
    if (en && w_push) begin
      r_stk[r_wp] <= w_addr_inc;
    end
  end

  assign stk_full  = w_full;
  assign stk_empty = w_empty;
  assign stk_err   = r_err;

`else

  logic w_unused;

  assign w_unused = ret;

  // Action select without a stack: call is an absolute jump, ret falls through.
  always_comb begin
    w_addr_nxt = w_addr_inc;
    if (call) begin
      w_addr_nxt = regBuf;
    end else if (brnch_yes) begin
      if (brnch_rel) begin
        w_addr_nxt = r_addr + regBuf;
      end else begin
        w_addr_nxt = regBuf;
      end
    end
  end

  // Fetch address register; holds while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= RESET_ADDR;
    end else if (en) begin
      r_addr <= w_addr_nxt;
    end
  end

  assign stk_full  = 1'b0;
  assign stk_empty = 1'b1;
  assign stk_err   = 1'b0;

`endif

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq (ADDR_W=8, DEPTH=4, RESET_ADDR=0x10).
// Adapts its stack expectations to whether PC_SEQ_CALLSTACK_EN is defined.
module tb_pc_seq;

  localparam int unsigned AW   = 8;
  localparam int unsigned DP   = 4;
  localparam logic [7:0]  RSTA = 8'h10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       brnch_yes = 1'b0;
  logic       brnch_rel = 1'b0;
  logic       call = 1'b0;
  logic       ret = 1'b0;
  logic [7:0] regBuf = '0;
  logic [7:0] addr;
  logic       stk_full;
  logic       stk_empty;
  logic       stk_err;

  int checks = 0;
  int failures = 0;

  // Reference model state: address, return stack as a queue (back = top), sticky error.
  int m_addr;
  int m_stk[$];
  bit m_err;

  // ctl = {en, brnch_yes, brnch_rel, call, ret}; fl = {full, empty, err}
  typedef struct {
    logic [4:0] ctl;
    logic [7:0] rb;
    logic [7:0] ea;
    logic [2:0] fl;
  } vec_t;

  vec_t tbl[$];

  pc_seq #(
    .ADDR_W    (AW),
    .DEPTH     (DP),
    .RESET_ADDR(RSTA)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .brnch_yes(brnch_yes),
    .brnch_rel(brnch_rel),
    .call     (call),
    .ret      (ret),
    .regBuf   (regBuf),
    .addr     (addr),
    .stk_full (stk_full),
    .stk_empty(stk_empty),
    .stk_err  (stk_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk4(input string nm, input logic [7:0] ea, input logic ef, input logic ee,
                      input logic er);
    check({nm, ".addr"}, 32'(addr), 32'(ea));
    check({nm, ".full"}, 32'(stk_full), 32'(ef));
    check({nm, ".empty"}, 32'(stk_empty), 32'(ee));
    check({nm, ".err"}, 32'(stk_err), 32'(er));
  endtask

  task automatic model_reset;
    m_addr = int'(RSTA);
    m_stk.delete();
    m_err = 1'b0;
  endtask

  task automatic model_step(input logic [4:0] c, input logic [7:0] rb);
    int off;
    if (!c[4]) return;
    off = (rb >= 8'd128) ? int'(rb) - 256 : int'(rb);
`ifdef PC_SEQ_CALLSTACK_EN
    if (c[0]) begin
      if (c[1]) m_err = 1'b1;
      if (m_stk.size() > 0) begin
        m_addr = m_stk.pop_back();
      end else begin
        m_addr = (m_addr + 1) % 256;
        m_err  = 1'b1;
      end
      return;
    end
    if (c[1]) begin
      m_stk.push_back((m_addr + 1) % 256);
      if (m_stk.size() > int'(DP)) begin
        void'(m_stk.pop_front());
        m_err = 1'b1;
      end
      m_addr = int'(rb);
      return;
    end
`else
    if (c[1]) begin
      m_addr = int'(rb);
      return;
    end
`endif
    if (c[3] && c[2]) m_addr = (m_addr + off) & 255;
    else if (c[3]) m_addr = int'(rb);
    else m_addr = (m_addr + 1) % 256;
  endtask

  task automatic check_model(input string nm);
    check({nm, ".addr"}, 32'(addr), 32'(m_addr[7:0]));
    check({nm, ".full"}, 32'(stk_full), 32'(m_stk.size() == int'(DP)));
    check({nm, ".empty"}, 32'(stk_empty), 32'(m_stk.size() == 0));
    check({nm, ".err"}, 32'(stk_err), 32'(m_err));
  endtask

  // Apply one cycle of controls away from the edge and sample 1 time unit after it.
  task automatic drive(input logic [4:0] c, input logic [7:0] rb);
    {en, brnch_yes, brnch_rel, call, ret} = c;
    regBuf = rb;
    model_step(c, rb);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    {en, brnch_yes, brnch_rel, call, ret} = '0;
    regBuf = '0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic async_reset_check(input string nm);
    #2;
    rst_n = 1'b0;
    #1;
    chk4(nm, RSTA, 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    tbl.push_back('{5'b10000, 8'h00, 8'h11, 3'b010});
    tbl.push_back('{5'b10000, 8'h00, 8'h12, 3'b010});
    tbl.push_back('{5'b10000, 8'h00, 8'h13, 3'b010});
    tbl.push_back('{5'b11000, 8'h20, 8'h20, 3'b010});
    tbl.push_back('{5'b11000, 8'h80, 8'h80, 3'b010});
    tbl.push_back('{5'b11100, 8'hFE, 8'h7E, 3'b010});
    tbl.push_back('{5'b11100, 8'h05, 8'h83, 3'b010});
    tbl.push_back('{5'b01010, 8'h00, 8'h83, 3'b010});
    tbl.push_back('{5'b01011, 8'h55, 8'h83, 3'b010});
    tbl.push_back('{5'b01110, 8'h00, 8'h83, 3'b010});
    tbl.push_back('{5'b11000, 8'hFE, 8'hFE, 3'b010});
    tbl.push_back('{5'b10000, 8'h00, 8'hFF, 3'b010});
    tbl.push_back('{5'b10000, 8'h00, 8'h00, 3'b010});
    tbl.push_back('{5'b11100, 8'h80, 8'h80, 3'b010});
    tbl.push_back('{5'b10100, 8'h33, 8'h81, 3'b010});

    do_reset();
    chk4("reset", RSTA, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ctl, tbl[i].rb);
      chk4($sformatf("vec%0d", i), tbl[i].ea, tbl[i].fl[2], tbl[i].fl[1], tbl[i].fl[0]);
    end

`ifdef PC_SEQ_CALLSTACK_EN
    // Nested call/return
    do_reset();
    drive(5'b10010, 8'h40); chk4("nest.call1", 8'h40, 1'b0, 1'b0, 1'b0);
    drive(5'b10010, 8'h60); chk4("nest.call2", 8'h60, 1'b0, 1'b0, 1'b0);
    drive(5'b10001, 8'h00); chk4("nest.ret1", 8'h41, 1'b0, 1'b0, 1'b0);
    drive(5'b10001, 8'h00); chk4("nest.ret2", 8'h11, 1'b0, 1'b1, 1'b0);

    // Overflow: five calls into four entries, oldest lost
    do_reset();
    drive(5'b10010, 8'h40); chk4("ovf.c1", 8'h40, 1'b0, 1'b0, 1'b0);
    drive(5'b10010, 8'h50); chk4("ovf.c2", 8'h50, 1'b0, 1'b0, 1'b0);
    drive(5'b10010, 8'h60); chk4("ovf.c3", 8'h60, 1'b0, 1'b0, 1'b0);
    drive(5'b10010, 8'h70); chk4("ovf.c4", 8'h70, 1'b1, 1'b0, 1'b0);
    drive(5'b10010, 8'h80); chk4("ovf.c5", 8'h80, 1'b1, 1'b0, 1'b1);
    drive(5'b10001, 8'h00); chk4("ovf.r1", 8'h71, 1'b0, 1'b0, 1'b1);
    drive(5'b10001, 8'h00); chk4("ovf.r2", 8'h61, 1'b0, 1'b0, 1'b1);
    drive(5'b10001, 8'h00); chk4("ovf.r3", 8'h51, 1'b0, 1'b0, 1'b1);
    drive(5'b10001, 8'h00); chk4("ovf.r4", 8'h41, 1'b0, 1'b1, 1'b1);
    drive(5'b10001, 8'h00); chk4("ovf.r5", 8'h42, 1'b0, 1'b1, 1'b1);

    // Underflow
    do_reset();
    drive(5'b11000, 8'h30); chk4("unf.br", 8'h30, 1'b0, 1'b1, 1'b0);
    drive(5'b10001, 8'h00); chk4("unf.ret", 8'h31, 1'b0, 1'b1, 1'b1);

    // Conflict, then asynchronous reset clears the sticky error
    do_reset();
    drive(5'b10010, 8'h40); chk4("cfl.call", 8'h40, 1'b0, 1'b0, 1'b0);
    drive(5'b10011, 8'h77); chk4("cfl.both", 8'h11, 1'b0, 1'b1, 1'b1);
    async_reset_check("cfl.arst");
    drive(5'b10000, 8'h00); chk4("cfl.after", 8'h11, 1'b0, 1'b1, 1'b0);

    // Stall with call/ret asserted leaves the stack intact
    do_reset();
    drive(5'b10010, 8'h40); chk4("stl.call", 8'h40, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(5'b01010, 8'h99); chk4($sformatf("stl.hold%0d", i), 8'h40, 1'b0, 1'b0, 1'b0);
    end
    drive(5'b10001, 8'h00); chk4("stl.ret", 8'h11, 1'b0, 1'b1, 1'b0);
`else
    // No stack: call is a plain jump, ret is ignored
    do_reset();
    drive(5'b10010, 8'h40); chk4("nostk.call", 8'h40, 1'b0, 1'b1, 1'b0);
    drive(5'b10001, 8'h00); chk4("nostk.ret", 8'h41, 1'b0, 1'b1, 1'b0);
    drive(5'b10011, 8'h60); chk4("nostk.both", 8'h60, 1'b0, 1'b1, 1'b0);
    drive(5'b11001, 8'h70); chk4("nostk.retbr", 8'h70, 1'b0, 1'b1, 1'b0);
    drive(5'b11101, 8'h02); chk4("nostk.retrel", 8'h72, 1'b0, 1'b1, 1'b0);
    drive(5'b10110, 8'h05); chk4("nostk.callrel", 8'h05, 1'b0, 1'b1, 1'b0);
`endif

    // Asynchronous reset between edges
    do_reset();
    drive(5'b11000, 8'h40); chk4("arst.br", 8'h40, 1'b0, 1'b1, 1'b0);
    async_reset_check("arst.mid");
    drive(5'b10000, 8'h00); chk4("arst.inc", 8'h11, 1'b0, 1'b1, 1'b0);

    // Randomised run against the reference model
    for (int n = 0; n < 600; n++) begin
      logic [4:0] c;
      if (n % 100 == 0) do_reset();
      c[4] = ($urandom_range(0, 9) != 0);
      c[3] = ($urandom_range(0, 2) == 0);
      c[2] = ($urandom_range(0, 1) == 1);
      c[1] = ($urandom_range(0, 4) == 0);
      c[0] = ($urandom_range(0, 4) == 0);
      drive(c, 8'($urandom));
      check_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program-sequencing unit, the next generation of the 8-bit computer's program counter. It produces the instruction fetch address for the memory block. It supports sequential increment, absolute and PC-relative branches, and subroutine call/return through an internal return-address stack of configurable depth. It sits between Control (branch/call/ret decode) and memory (mem_addr), and takes branch targets from the shift-register file output.

## Interface
Parameters:
- ADDR_W, 8, address width in bits (≥4)
- DEPTH, 4, return-stack entries (≥1)
- RESET_ADDR, 0, addr value after reset

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- en  in  1  advance enable; 0 = stall, all other controls ignored
- brnch_yes  in  1  take branch to target
- brnch_rel  in  1  1 = relative branch, 0 = absolute branch
- call  in  1  push return address, then jump to target (absolute)
- ret  in  1  pop return address into addr
- regBuf  in  ADDR_W  branch/call target or signed offset
- addr  out  ADDR_W  current fetch address (registered)
- stk_full  out  1  stack holds DEPTH entries
- stk_empty  out  1  stack holds 0 entries
- stk_err  out  1  sticky overflow/underflow/conflict flag

## Operation
- State: addr register, stack array of DEPTH×ADDR_W, count of 0..DEPTH, stk_err.
- Each enabled cycle selects exactly one action. Priority is highest first:
  1. ret & call both high: conflict. Set stk_err and perform ret only.
  2. ret: if count>0, addr ← top and count−1. If count==0 (underflow), addr ← addr+1, count stays 0, and stk_err is set.
  3. call: push addr+1, then addr ← regBuf and count+1. If count==DEPTH (overflow), the push overwrites the oldest entry and count stays DEPTH. The stack is circular, so the top pointer still advances. stk_err is set and the jump is still taken.
  4. brnch_yes & brnch_rel: addr ← addr + sign-extend(regBuf). Arithmetic is modulo 2^ADDR_W.
  5. brnch_yes & !brnch_rel: addr ← regBuf.
  6. Otherwise: addr ← addr+1. The address wraps from 2^ADDR_W−1 to 0.
- brnch_rel is ignored for call, because a call is always absolute.
- en=0: addr, stack, count and stk_err all hold.
- stk_full = (count==DEPTH) and stk_empty = (count==0). Both are decoded from the registered count.
- stk_err is cleared only by reset.

## Timing
- The addr register updates on the rising clk edge. The new address is visible on addr one cycle after the controls are sampled.
- Latency from any control to addr is 1 cycle. There is no combinational path from the inputs to any output.
- The stack flags change in the same cycle as the count update.
- A push followed by a pop in consecutive cycles returns the pushed value, with no bubble.
- Reset, asynchronous on rst_n fall:
  - addr = RESET_ADDR, count = 0, stk_err = 0.
  - stk_full = 0 and stk_empty = 1.
  - Stack contents are undefined and unobservable.
- Reset applied mid-call or mid-ret aborts the action, and the reset values win.
- Release of rst_n is synchronised externally. The first update occurs on the first rising edge with rst_n high.

## Configuration
- Macro PC_SEQ_CALLSTACK_EN.
- Defined: the return stack and the call/ret behaviour are built as above.
- Undefined: no stack storage is built.
  - call behaves as an absolute branch, with no push.
  - ret is ignored, with increment unless a branch is active.
  - stk_full = 0, stk_empty = 1 and stk_err = 0 constantly.
  - DEPTH is unused.

## Test plan
- Reset and increment: with RESET_ADDR=0x10, release rst_n and hold en=1 for 3 cycles. addr must read 0x10, 0x11, 0x12, 0x13. Then, from addr=0xFF, addr must wrap to 0x00.
- Branches: at addr=0x20, apply an absolute branch with regBuf=0x80, giving addr=0x80. Then a relative branch with regBuf=0xFE gives addr=0x7E. Then a relative branch with regBuf=0x05 gives 0x83.
- Call/return nesting: with DEPTH=4, call at 0x10 with target 0x40, then call at 0x40 with target 0x60. stk_empty must be 0. Two rets must give addr=0x41, then 0x11, then stk_empty=1 and stk_err=0.
- Overflow: perform 5 calls with DEPTH=4. stk_full must be 1 after the 4th call and stk_err must be 1 after the 5th. Four rets must then return the last 4 return addresses in LIFO order, with the oldest lost.
- Underflow and conflict: ret when empty at addr=0x30 gives addr=0x31 and stk_err=1. After reset, call and ret together with one entry pushed must pop that entry and set stk_err=1.
- Stall and async reset: en=0 for 3 cycles with branch/call asserted leaves addr and count unchanged. Dropping rst_n between edges must force addr=RESET_ADDR immediately. With the macro undefined, call gives a jump only and stk_empty stays 1.
